crc16_frame_checker: RTL and testbench
======================================

CRC16_FRAME_CHECKER -- requirements
Module: crc16_frame_checker

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 256, meaning the maximum frame length in words, CRC word included; legal range 2..256.
REQ-002 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1, input word valid.
REQ-005 SHALL have port in_ready, output, 1, checker can accept a word.
REQ-006 SHALL have port in_data, input, 16, payload word or trailing CRC word.
REQ-007 SHALL have port in_sof, input, 1, first word of frame; qualified by in_valid.
REQ-008 SHALL have port in_eof, input, 1, last word of frame, which is the CRC word; qualified by in_valid.
REQ-009 SHALL have port status_valid, output, 1, one-cycle pulse: a frame result is presented.
REQ-010 SHALL have port status_ok, output, 1, frame passed with no error; valid when status_valid=1.
REQ-011 SHALL have port status_err, output, 3, error code {overflow, runt, crc_mismatch}; valid when status_valid=1.
REQ-012 SHALL have port status_len, output, 9, frame word count including the CRC word; valid when status_valid=1.
REQ-013 SHALL have port good_cnt, output, 16, saturating count of good frames.
REQ-014 SHALL have port bad_cnt, output, 16, saturating count of bad frames.

Function
REQ-015 A word SHALL be accepted only on a clock edge where in_valid=1 and in_ready=1.
REQ-016 The FSM SHALL have exactly three states: IDLE, ACTIVE, REPORT.
REQ-017 in_ready SHALL be 1 in IDLE and ACTIVE, and 0 in REPORT.
REQ-018 CRC arithmetic SHALL be CRC-CCITT: poly 0x1021, init 0xFFFF, no reflection, no final XOR, 16 bits per word, MSB (bit 15) first.
REQ-019 IDLE, accepted word with in_sof=1 and in_eof=0: load crc = CRC(0xFFFF, in_data), len = 1, go to ACTIVE.
REQ-020 IDLE, accepted word with in_sof=1 and in_eof=1: runt frame, len = 1, go to REPORT.
REQ-021 IDLE, accepted word with in_sof=0: discard silently; no status, no counter change.
REQ-022 ACTIVE, accepted word with in_sof=0 and in_eof=0: crc = CRC(crc, in_data), len += 1.
REQ-023 ACTIVE, when len reaches MAX_WORDS without eof: flag overflow.
REQ-024 ACTIVE, accepted word with in_eof=1: set crc_mismatch = (in_data != crc); the CRC word SHALL NOT enter crc; len += 1; go to REPORT.
REQ-025 ACTIVE, accepted word with in_sof=1: abort the current frame.
- Report it as runt if len < 2, otherwise as overflow=0, crc_mismatch=1.
- The sof word SHALL then be lost, not restarted.
- Go to REPORT.
REQ-026 Overflow: once flagged, further non-eof words SHALL be consumed without updating crc or len; at eof, go to REPORT with the overflow bit set.
REQ-027 REPORT SHALL last exactly one cycle with status_valid=1, then return to IDLE.
- Status latency: status_valid is asserted the cycle after the eof-word acceptance edge.
REQ-028 status_ok SHALL be 1 iff status_err == 3'b000.
REQ-029 status_ok/status_err/status_len SHALL hold their last values while status_valid=0.
REQ-030 Counters: in REPORT, increment good_cnt if status_ok=1, else bad_cnt; each saturates at 0xFFFF.

Reset
REQ-031 reset=1 SHALL immediately set:
- state = IDLE, crc = 0xFFFF, len = 0;
- status_valid = 0, status_ok = 0, status_err = 0, status_len = 0;
- good_cnt = 0, bad_cnt = 0.
- in_ready SHALL be 1 after reset.
REQ-032 Reset asserted mid-frame or in REPORT SHALL drop the frame with no status pulse and no counter change.

Verification
REQ-033 Frame {0xFFFF(sof), 0x0000(eof)} -> next cycle: status_valid=1, status_ok=1, status_err=000, status_len=2, good_cnt=1.
REQ-034 Frame {0xFFFF(sof), 0x0000, 0x0000(eof)} -> status_ok=1, status_len=3; then {0xFFFF(sof), 0x0001(eof)} -> status_err=001, bad_cnt=1.
REQ-035 Single word with sof=eof=1 -> status_err=010, status_len=1, bad_cnt increments; a word with in_sof=0 in IDLE -> no status_valid pulse.
REQ-036 MAX_WORDS=4, frame of 6 words -> status_err=100, status_len=4, in_ready=0 only in the REPORT cycle.
REQ-037 Frame with sof again at word 3 -> status_err=001, status_len=2; the following word without sof is discarded.
REQ-038 Reset pulse during word 2 of a frame -> all outputs zero, in_ready=1, no status pulse; the next good frame gives good_cnt=1.

Source files
------------

// File: rtl/crc16_frame_checker.sv
// CRC-CCITT frame checker: accumulates a CRC over a framed word stream, compares it
// against the trailing CRC word and reports per-frame status plus good/bad counters.
module crc16_frame_checker #(
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_sof,
    input  logic        in_eof,
    output logic        status_valid,
    output logic        status_ok,
    output logic [2:0]  status_err,
    output logic [8:0]  status_len,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
);

    typedef enum logic [1:0] {IDLE, ACTIVE, REPORT} state_t;

    localparam logic [8:0] MAX_LEN = 9'(MAX_WORDS);

    state_t      state;
    logic [15:0] crc;
    logic [8:0]  len;
    logic        ovf;

    logic        accept;
    logic        rep_go;
    logic [2:0]  rep_err;
    logic [8:0]  rep_len;

    function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        logic [15:0] dd;
        logic        fb;
        r  = c;
        dd = d;
        for (int unsigned i = 0; i < 16; i++) begin
            fb = r[15] ^ dd[15];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            dd = {dd[14:0], 1'b0};
        end
        return r;
    endfunction

    assign in_ready = (state != REPORT);
    assign accept   = in_valid && in_ready;

    // Frame-terminating events: decides whether the next cycle is REPORT and with what status.
    always_comb begin
        rep_go  = 1'b0;
        rep_err = '0;
        rep_len = len;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (in_sof && in_eof) begin
                        rep_go  = 1'b1;
                        rep_err = 3'b010;
                        rep_len = 9'd1;
                    end
                end
                ACTIVE: begin
                    if (in_sof) begin
                        rep_go  = 1'b1;
                        rep_err = (len < 9'd2) ? 3'b010 : 3'b001;
                    end else if (in_eof) begin
                        rep_go = 1'b1;
                        if (ovf) begin
                            rep_err = 3'b100;
                        end else begin
                            rep_err = {2'b00, in_data != crc};
                            rep_len = len + 9'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            crc          <= 16'hFFFF;
            len          <= '0;
            ovf          <= 1'b0;
            status_valid <= 1'b0;
            status_ok    <= 1'b0;
            status_err   <= '0;
            status_len   <= '0;
            good_cnt     <= '0;
            bad_cnt      <= '0;
        end else begin
            status_valid <= rep_go;
            if (rep_go) begin
                state      <= REPORT;
                ovf        <= 1'b0;
                status_err <= rep_err;
                status_ok  <= (rep_err == 3'b000);
                status_len <= rep_len;
                if (rep_err == 3'b000) begin
                    if (good_cnt != '1) good_cnt <= good_cnt + 16'd1;
                end else begin
                    if (bad_cnt != '1) bad_cnt <= bad_cnt + 16'd1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (accept && in_sof) begin
                            crc   <= crc_word(16'hFFFF, in_data);
                            len   <= 9'd1;
                            ovf   <= 1'b0;
                            state <= ACTIVE;
                        end
                    end
                    ACTIVE: begin
                        if (accept && !ovf) begin
                            crc <= crc_word(crc, in_data);
                            len <= len + 9'd1;
                            if (len + 9'd1 == MAX_LEN) ovf <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        crc   <= 16'hFFFF;
                        len   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_crc16_frame_checker.sv
// Randomized and directed bench for crc16_frame_checker against a queue-based frame model.
module tb_crc16_frame_checker;

    localparam int unsigned MW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_sof;
    logic        in_eof;
    logic        status_valid;
    logic        status_ok;
    logic [2:0]  status_err;
    logic [8:0]  status_len;
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;

    always #5 clk = ~clk;

    crc16_frame_checker #(.MAX_WORDS(MW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sof(in_sof), .in_eof(in_eof),
        .status_valid(status_valid), .status_ok(status_ok),
        .status_err(status_err), .status_len(status_len),
        .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Model of the frame stream: words of the open frame kept in a queue.
    bit          in_frame;
    bit          ovf;
    logic [15:0] q[$];
    bit          exp_valid;
    bit          exp_ok;
    logic [2:0]  exp_err;
    int unsigned exp_len;
    int unsigned exp_good;
    int unsigned exp_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc_of(input logic [15:0] words[$]);
        logic [15:0] c = 16'hFFFF;
        logic [15:0] w;
        foreach (words[k]) begin
            w = words[k];
            for (int b = 15; b >= 0; b--) begin
                c = (c[15] ^ w[b]) ? ((c << 1) ^ 16'h1021) : (c << 1);
            end
        end
        return c;
    endfunction

    task automatic model_clear();
        in_frame = 0; ovf = 0; q = {};
        exp_valid = 0; exp_ok = 0; exp_err = '0; exp_len = 0;
        exp_good = 0; exp_bad = 0;
    endtask

    task automatic step(input bit v, input logic [15:0] d, input bit s, input bit e, output bit acc);
        bit          emit;
        logic [2:0]  err;
        int unsigned len;
        @(negedge clk);
        check("status_valid", status_valid, exp_valid);
        check("in_ready", in_ready, !exp_valid);
        check("status_ok", status_ok, exp_ok);
        check("status_err", status_err, exp_err);
        check("status_len", status_len, exp_len);
        check("good_cnt", good_cnt, exp_good);
        check("bad_cnt", bad_cnt, exp_bad);
        in_valid = v; in_data = d; in_sof = s; in_eof = e;
        acc  = v && !exp_valid;
        emit = 0; err = '0; len = 0;
        if (acc) begin
            if (!in_frame) begin
                if (s && e) begin emit = 1; err = 3'b010; len = 1; end
                else if (s) begin in_frame = 1; ovf = 0; q = {d}; end
            end else if (s) begin
                emit = 1; err = (q.size() < 2) ? 3'b010 : 3'b001; len = q.size();
            end else if (e) begin
                emit = 1;
                if (ovf) begin err = 3'b100; len = q.size(); end
                else begin err = (crc_of(q) != d) ? 3'b001 : 3'b000; len = q.size() + 1; end
            end else if (!ovf) begin
                q.push_back(d);
                if (q.size() == MW) ovf = 1;
            end
        end
        if (emit) begin
            in_frame = 0;
            exp_err = err; exp_ok = (err == 3'b000); exp_len = len;
            if (exp_ok) begin if (exp_good < 65535) exp_good++; end
            else begin if (exp_bad < 65535) exp_bad++; end
        end
        exp_valid = emit;
    endtask

    task automatic send(input logic [15:0] d, input bit s, input bit e);
        bit acc = 0;
        int unsigned tries = 0;
        while (!acc && tries < 3) begin
            step(1'b1, d, s, e, acc);
            tries++;
        end
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int unsigned n);
        bit acc;
        for (int unsigned i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0, 1'b0, acc);
    endtask

    // Reset applied between clock edges, optionally while a word is on the bus.
    task automatic do_reset(input bit with_word);
        @(negedge clk);
        in_valid = with_word; in_data = 16'h1234; in_sof = 0; in_eof = 0;
        #2 reset = 1'b1;
        #1;
        check("rst_status_valid", status_valid, 1'b0);
        check("rst_status_ok", status_ok, 1'b0);
        check("rst_status_err", status_err, 3'b000);
        check("rst_status_len", status_len, 9'd0);
        check("rst_good_cnt", good_cnt, 16'd0);
        check("rst_bad_cnt", bad_cnt, 16'd0);
        check("rst_in_ready", in_ready, 1'b1);
        model_clear();
        @(negedge clk);
        in_valid = 0;
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] frame[$];
        logic [15:0] w;
        int unsigned n;
        reset = 1'b1; in_valid = 0; in_data = '0; in_sof = 0; in_eof = 0;
        model_clear();
        do_reset(1'b0);

        send(16'hFFFF, 1, 0); send(16'h0000, 0, 1); idle(1);
        check("good_frame_len", status_len, 9'd2);
        check("good_frame_cnt", good_cnt, 16'd1);

        send(16'hFFFF, 1, 0); send(16'h0000, 0, 0); send(16'h0000, 0, 1); idle(1);
        check("three_word_len", status_len, 9'd3);
        send(16'hFFFF, 1, 0); send(16'h0001, 0, 1); idle(1);
        check("crc_bad_err", status_err, 3'b001);
        check("crc_bad_cnt", bad_cnt, 16'd1);

        send(16'hABCD, 1, 1); idle(1);
        check("runt_err", status_err, 3'b010);
        check("runt_len", status_len, 9'd1);
        send(16'h5555, 0, 0); idle(2);

        send(16'h1111, 1, 0);
        for (int unsigned i = 0; i < 4; i++) send(16'(i * 7 + 3), 0, 0);
        send(16'h9999, 0, 1); idle(1);
        check("overflow_err", status_err, 3'b100);
        check("overflow_len", status_len, 9'd4);
        check("overflow_ready", in_ready, 1'b0);

        send(16'h2222, 1, 0); send(16'h3333, 0, 0); send(16'h4444, 1, 0);
        send(16'h5555, 0, 0); idle(1);
        check("abort_err", status_err, 3'b001);
        check("abort_len", status_len, 9'd2);
        check("abort_bad_cnt", bad_cnt, 16'd4);

        send(16'hFFFF, 1, 0);
        do_reset(1'b1);
        idle(2);
        send(16'hFFFF, 1, 0); send(16'h0000, 0, 1); idle(1);
        check("post_reset_good", good_cnt, 16'd1);

        for (int unsigned f = 0; f < 400; f++) begin
            n = $urandom_range(1, 7);
            frame = {};
            for (int unsigned i = 0; i < n; i++) frame.push_back(16'($urandom));
            if ($urandom_range(0, 7) == 0) send(16'($urandom), 0, $urandom_range(0, 1) == 1);
            if (n == 1) begin
                send(frame[0], 1, 1);
            end else begin
                send(frame[0], 1, 0);
                for (int unsigned i = 1; i < n - 1; i++) begin
                    send(frame[i], $urandom_range(0, 15) == 0, 0);
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                end
                w = frame[n - 1];
                if ($urandom_range(0, 1) == 1) begin
                    frame.pop_back();
                    w = crc_of(frame);
                end
                send(w, 0, 1);
            end
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            if (f == 200) begin
                send(16'hFFFF, 1, 0);
                do_reset(1'b1);
            end
        end
        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
